// File: rtl/line_data_memory_if.sv
// Line-granular request/response bus between the dcache miss/writeback port
// and the backing line memory.
interface line_data_memory_if;
  logic         enable_i;
  logic         write_i;
  logic [31:0]  addr_i;
  logic [255:0] data_i;
  logic         ack_o;
  logic [255:0] data_o;

  modport master (
    output enable_i, write_i, addr_i, data_i,
    input  ack_o, data_o
  );

  modport slave (
    input  enable_i, write_i, addr_i, data_i,
    output ack_o, data_o
  );
endinterface

// File: rtl/line_data_memory.sv
// Backing line memory: latches one request, commits it after LATENCY cycles,
// pulses ack for one cycle, then spends one turnaround cycle before re-sampling.
//
//   state | meaning
//   IDLE  | waiting; enable samples a new request into the req regs
//   BUSY  | counting down the access latency, inputs ignored
//   ACK   | access committed on entry; ack_o high for this cycle only
//   TURN  | absorbs the cycle the cache still drives enable after ack
module line_data_memory #(
  parameter int LATENCY = 10,
  parameter int IDX_W   = 9,
  parameter int LINE_W  = 256
) (
  input logic               clk_i,
  input logic               rst_i,
  line_data_memory_if.slave bus
);
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam int DEPTH = 2 ** IDX_W;

  typedef enum logic [1:0] {IDLE, BUSY, ACK, TURN} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_write_q;
  logic [IDX_W-1:0]  req_idx_q;
  logic [LINE_W-1:0] req_data_q;
  logic [LINE_W-1:0] rdata_q;
  logic [LINE_W-1:0] mem [DEPTH];

  logic              latch_req;
  logic              commit;
  logic              c_write;
  logic [IDX_W-1:0]  c_idx;
  logic [LINE_W-1:0] c_data;
  logic              unused_addr;

  assign unused_addr = ^{bus.addr_i[31:5+IDX_W], bus.addr_i[4:0]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    latch_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.enable_i) begin
          latch_req = 1'b1;
          cnt_d     = CNT_W'(LATENCY - 1);
          state_d   = (LATENCY > 1) ? BUSY : ACK;
        end
      end
      BUSY: begin
        if (cnt_q == CNT_W'(1)) state_d = ACK;
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      end
      ACK:     state_d = TURN;
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With LATENCY=1 the commit edge is also the sample edge, so the live
  // inputs are used directly; otherwise the latched request is used.
  always_comb begin
    commit  = (state_d == ACK);
    c_write = latch_req ? bus.write_i : req_write_q;
    c_idx   = latch_req ? bus.addr_i[5+IDX_W-1:5] : req_idx_q;
    c_data  = latch_req ? bus.data_i : req_data_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_write_q <= 1'b0;
      req_idx_q   <= '0;
      req_data_q  <= '0;
      rdata_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch_req) begin
        req_write_q <= bus.write_i;
        req_idx_q   <= bus.addr_i[5+IDX_W-1:5];
        req_data_q  <= bus.data_i;
      end
      if (commit && !c_write) rdata_q <= mem[c_idx];
    end
  end

  // Storage is never cleared; reset only blocks a commit on the same edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (!rst_i) begin
      if (commit && c_write) mem[c_idx] <= c_data;
    end
  end

  assign bus.ack_o  = (state_q == ACK);
  assign bus.data_o = rdata_q;
endmodule

// File: tb/tb_line_data_memory.sv
// Bench for line_data_memory: a LATENCY=10 and a LATENCY=1 instance share the
// same stimulus and are checked every cycle against a request-level model.
module tb_line_data_memory;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         wr = 1'b0;
  logic [31:0]  addr = '0;
  logic [255:0] wdata = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  line_data_memory_if bus0 ();
  line_data_memory_if bus1 ();

  assign bus0.enable_i = en;
  assign bus0.write_i  = wr;
  assign bus0.addr_i   = addr;
  assign bus0.data_i   = wdata;
  assign bus1.enable_i = en;
  assign bus1.write_i  = wr;
  assign bus1.addr_i   = addr;
  assign bus1.data_i   = wdata;

  line_data_memory #(.LATENCY(10)) dut0 (.clk_i(clk), .rst_i(rst), .bus(bus0));
  line_data_memory #(.LATENCY(1))  dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1));

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 10 : 1;
  endfunction

  // Request-level model: a request accepted at posedge n acks in the
  // LATENCY-th cycle after n (commit on edge n+LATENCY-1), and the next
  // request can be accepted no earlier than edge n+LATENCY+2.
  int           cyc = 0;
  int           ack_edge [2] = '{-1, -1};
  int           next_free [2] = '{0, 0};
  bit           pend_w [2];
  int           pend_idx [2];
  logic [255:0] pend_d [2];
  logic [255:0] mem_m [2][512];
  bit           known [2][512];
  bit           ack_exp [2];
  logic [255:0] exp_d [2];
  bit           exp_v [2] = '{1'b0, 1'b0};

  always @(posedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        ack_exp[d]   = 1'b0;
        ack_edge[d]  = -1;
        next_free[d] = 0;
        exp_d[d]     = '0;
        exp_v[d]     = 1'b1;
      end else begin
        if (en && cyc >= next_free[d]) begin
          ack_edge[d]  = cyc + lat_of(d) - 1;
          next_free[d] = cyc + lat_of(d) + 2;
          pend_w[d]    = wr;
          pend_idx[d]  = int'((addr >> 5) % 512);
          pend_d[d]    = wdata;
        end
        ack_exp[d] = (cyc == ack_edge[d]);
        if (ack_exp[d]) begin
          if (pend_w[d]) begin
            mem_m[d][pend_idx[d]] = pend_d[d];
            known[d][pend_idx[d]] = 1'b1;
          end else begin
            exp_d[d] = mem_m[d][pend_idx[d]];
            exp_v[d] = known[d][pend_idx[d]];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ack0", 256'(bus0.ack_o), '0);
      chk("rst_data0", bus0.data_o, '0);
      chk("rst_ack1", 256'(bus1.ack_o), '0);
      chk("rst_data1", bus1.data_o, '0);
    end else begin
      chk("ack0", 256'(bus0.ack_o), 256'(ack_exp[0]));
      if (exp_v[0]) chk("data0", bus0.data_o, exp_d[0]);
      chk("ack1", 256'(bus1.ack_o), 256'(ack_exp[1]));
      if (exp_v[1]) chk("data1", bus1.data_o, exp_d[1]);
    end
  end

  task automatic scramble();
    addr  = $urandom;
    wdata = rand256();
    wr    = 1'($urandom_range(0, 1));
  endtask

  // lat counts cycles after the sample edge until ack is seen (bounded).
  task automatic wait_ack(input int d, input bit scr, output int lat);
    lat = 1;
    while (!(d == 1 ? bus1.ack_o : bus0.ack_o) && lat < 40) begin
      @(posedge clk); #2;
      lat++;
      if (scr) scramble();
    end
  endtask

  task automatic req(input int d, input bit w, input logic [31:0] a,
                     input logic [255:0] dat, input bit hold, output int lat);
    repeat (2) @(posedge clk);
    #2;
    en = 1'b1; wr = w; addr = a; wdata = dat;
    @(posedge clk); #2;
    if (!hold) begin
      en = 1'b0;
      scramble();
    end
    wait_ack(d, !hold, lat);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int seen;
    logic [255:0] a5, p1, d3, d4, p6, q0, q511;
    a5   = {32{8'hA5}};
    p1   = rand256();
    d3   = rand256();
    d4   = rand256();
    p6   = rand256();
    q0   = rand256();
    q511 = rand256();

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ack", 256'(bus0.ack_o), '0);
    chk("reset_data", bus0.data_o, '0);
    @(posedge clk); #2;
    rst = 1'b0;

    // read latency, one-cycle ack, data held
    req(0, 1'b1, 32'h60, a5, 1'b0, lat);
    chk("t1_wr_lat", 256'(lat), 256'd10);
    req(0, 1'b0, 32'h60, '0, 1'b0, lat);
    chk("t1_rd_lat", 256'(lat), 256'd10);
    chk("t1_rd_data", bus0.data_o, a5);
    @(posedge clk); #2;
    chk("t1_ack_width", 256'(bus0.ack_o), '0);
    repeat (5) @(posedge clk);
    #1;
    chk("t1_data_held", bus0.data_o, a5);

    // write then read back at minimum spacing
    req(0, 1'b1, 32'h80, 256'h1234, 1'b0, lat);
    req(0, 1'b0, 32'h80, '0, 1'b0, lat);
    chk("t2_rd_lat", 256'(lat), 256'd10);
    chk("t2_rd_data", bus0.data_o, 256'h1234);

    // enable held across ack: re-sampled as a read once back in IDLE
    req(0, 1'b1, 32'h20, p1, 1'b0, lat);
    req(0, 1'b1, 32'h40, d3, 1'b1, lat);
    chk("t3_wr_lat", 256'(lat), 256'd10);
    @(posedge clk); #2;
    wr = 1'b0; addr = 32'h20;
    @(posedge clk);
    @(posedge clk); #2;
    en = 1'b0;
    wait_ack(0, 1'b0, lat);
    chk("t3_rd_lat", 256'(lat), 256'd10);
    chk("t3_rd_data", bus0.data_o, p1);
    req(0, 1'b0, 32'h40, '0, 1'b0, lat);
    chk("t3_wr_landed", bus0.data_o, d3);

    // inputs churn during BUSY; latched request wins
    req(0, 1'b1, 32'hE0, d4, 1'b0, lat);
    req(0, 1'b0, 32'hE0, '0, 1'b0, lat);
    chk("t4_rd_data", bus0.data_o, d4);

    // reset mid-write drops the write
    req(0, 1'b1, 32'hC0, p6, 1'b0, lat);
    repeat (2) @(posedge clk);
    #2;
    en = 1'b1; wr = 1'b1; addr = 32'hC0; wdata = ~p6;
    @(posedge clk); #2;
    en = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_ack", 256'(bus0.ack_o), '0);
    chk("t5_rst_data", bus0.data_o, '0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (bus0.ack_o) seen++;
    end
    chk("t5_no_ack", 256'(seen), '0);
    chk("t5_data_zero", bus0.data_o, '0);
    req(0, 1'b0, 32'hC0, '0, 1'b0, lat);
    chk("t5_rd_lat", 256'(lat), 256'd10);
    chk("t5_line_kept", bus0.data_o, p6);

    // LATENCY=1 instance, top index and wrapped alias
    repeat (12) @(posedge clk);
    req(1, 1'b1, 32'h3FE0, q511, 1'b0, lat);
    chk("t6_wr_lat", 256'(lat), 256'd1);
    repeat (12) @(posedge clk);
    req(1, 1'b1, 32'h0, q0, 1'b0, lat);
    repeat (12) @(posedge clk);
    req(1, 1'b0, 32'h3FE0, '0, 1'b0, lat);
    chk("t6_rd_lat", 256'(lat), 256'd1);
    chk("t6_idx511", bus1.data_o, q511);
    repeat (12) @(posedge clk);
    req(1, 1'b0, 32'h4000, '0, 1'b0, lat);
    chk("t6_alias0", bus1.data_o, q0);

    // randomized traffic with occasional reset pulses
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] a;
      @(posedge clk); #2;
      a = $urandom;
      a[13:5] = ($urandom_range(0, 15) == 0) ? 9'd511 : 9'($urandom_range(0, 7));
      en    = ($urandom_range(0, 3) == 0);
      wr    = 1'($urandom_range(0, 1));
      addr  = a;
      wdata = rand256();
      rst   = ($urandom_range(0, 199) == 0);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    en  = 1'b0;
    repeat (20) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
